// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//
// Types and constants shared by the pipelined CPU datapath.
//
//   pipe_state_t : occupancy of a skid-buffered pipeline stage register
//                  PS_EMPTY - nothing held
//                  PS_ONE   - main entry valid, skid entry empty
//                  PS_FULL  - main and skid entries both valid
//   NOP_INST     : instruction encoding loaded into instruction registers
//                  on reset and on flush, so a squashed slot decodes as a
//                  harmless no-op.
// ---------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY,
      PS_ONE,
      PS_FULL
   } pipe_state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/pipe_data_reg.sv
// ---------------------------------------------------------------------------
// pipe_data_reg
//
// N-bit payload register used for the main and skid entries of a pipeline
// stage. Loads only when told to, so payload bits never depend on in_data
// while the upstream side is idle.
//
// Parameters
//   N          payload width in bits
//   RESET_VAL  value after reset and after a synchronous clear
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset -> q = RESET_VAL
//   load   in   capture d on the next edge
//   clr    in   load RESET_VAL on the next edge; wins over load
//   d      in   N-bit data to capture
//   q      out  N-bit registered payload
// ---------------------------------------------------------------------------
module pipe_data_reg #(
   parameter int            N         = 32,
   parameter logic [N-1:0]  RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         clr,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] q_q;
   logic [N-1:0] q_d;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      q_d = q_q;
      if (clr) begin
         q_d = RESET_VAL;
      end else if (load) begin
         q_d = d;
      end
   end

   // NOTE: the payload is reset to RESET_VAL rather than left undefined; a
   // squashed or fresh stage must present a NOP, not garbage, downstream.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (reset) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : pipe_data_reg

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline register placed between CPU datapath stages (F/D/E/M/W). Carries
// an N-bit payload under a valid/ready handshake so stages can stall, a
// synchronous flush that squashes wrong-path work after a taken branch or
// jump, and a saturating stall counter for performance monitoring.
//
// Parameters
//   N          payload width in bits (1..256)
//   SKID       0: single register, in_ready is combinational from out_ready
//              1: main + skid register, in_ready comes straight from a flop
//   RESET_VAL  payload after reset and after flush (NOP for instructions)
//   CNT_W      stall counter width
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   flush      in   synchronous squash of all held entries
//   in_valid   in   upstream offers in_data
//   in_ready   out  this stage accepts a payload this cycle
//   in_data    in   N-bit upstream payload
//   out_valid  out  out_data is valid
//   out_ready  in   downstream consumes out_data this cycle
//   out_data   out  N-bit payload presented downstream
//   stall_cnt  out  cycles with out_valid && !out_ready, saturating
//   cnt_clr    in   synchronous clear of stall_cnt, wins over increment
// ---------------------------------------------------------------------------
module pipe_stage_reg
   import cpu_pkg::*;
#(
   parameter int            N         = 32,
   parameter int            SKID      = 1,
   parameter logic [N-1:0]  RESET_VAL = '0,
   parameter int            CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [CNT_W-1:0] stall_cnt,
   input  logic             cnt_clr
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Handshake events, evaluated against the values seen before the edge.
   logic up_xfer;
   logic dn_xfer;

   // Main entry: always present, its output is out_data.
   logic         main_load;
   logic [N-1:0] main_d;
   logic [N-1:0] main_q;

   assign up_xfer = in_valid && in_ready;
   assign dn_xfer = out_valid && out_ready;

   // Flush drives the clear input, which beats load inside the register,
   // so a payload offered during the flush cycle is dropped.
   pipe_data_reg #(
      .N         (N),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load),
      .clr   (flush),
      .d     (main_d),
      .q     (main_q)
   );

   assign out_data = main_q;

   generate
      if (SKID == 0) begin : g_single
         // -----------------------------------------------------------------
         // Single register. A held payload can be replaced in the same cycle
         // it leaves, which needs in_ready to look at out_ready directly.
         // -----------------------------------------------------------------
         logic out_valid_q;
         logic out_valid_d;

         always_comb begin
            out_valid_d = out_valid_q;
            if (flush) begin
               out_valid_d = 1'b0;
            end else if (up_xfer) begin
               out_valid_d = 1'b1;
            end else if (dn_xfer) begin
               out_valid_d = 1'b0;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               out_valid_q <= 1'b0;
            end else begin
               out_valid_q <= out_valid_d;
            end
         end

         assign out_valid = out_valid_q;
         assign in_ready  = !out_valid_q || out_ready;
         assign main_load = up_xfer;
         assign main_d    = in_data;

      end else begin : g_skid
         // -----------------------------------------------------------------
         // Main + skid. in_ready is registered, so upstream may still push
         // one payload after downstream stalls; the skid entry catches it.
         // -----------------------------------------------------------------
         pipe_state_t  state_q;
         pipe_state_t  state_d;
         logic         in_ready_q;
         logic         in_ready_d;
         logic         out_valid_q;
         logic         out_valid_d;
         logic         skid_load;
         logic [N-1:0] skid_q;

         always_comb begin
            state_d   = state_q;
            main_load = 1'b0;
            main_d    = in_data;
            skid_load = 1'b0;

            case (state_q)
               PS_EMPTY: begin
                  if (up_xfer) begin
                     state_d   = PS_ONE;
                     main_load = 1'b1;
                  end
               end
               PS_ONE: begin
                  if (up_xfer && dn_xfer) begin
                     // Main leaves and is refilled in the same edge.
                     main_load = 1'b1;
                  end else if (up_xfer) begin
                     state_d   = PS_FULL;
                     skid_load = 1'b1;
                  end else if (dn_xfer) begin
                     state_d   = PS_EMPTY;
                  end
               end
               PS_FULL: begin
                  // in_ready is low here, so only a drain can happen; the
                  // older skid payload moves up to keep FIFO order.
                  if (dn_xfer) begin
                     state_d   = PS_ONE;
                     main_load = 1'b1;
                     main_d    = skid_q;
                  end
               end
               default: begin
                  state_d = PS_EMPTY;
               end
            endcase

            if (flush) begin
               state_d = PS_EMPTY;
            end

            // Both handshake outputs are precomputed from the next state so
            // they leave the block straight from flops.
            in_ready_d  = (state_d != PS_FULL);
            out_valid_d = (state_d != PS_EMPTY);
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state_q     <= PS_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end else begin
               state_q     <= state_d;
               in_ready_q  <= in_ready_d;
               out_valid_q <= out_valid_d;
            end
         end

         pipe_data_reg #(
            .N         (N),
            .RESET_VAL (RESET_VAL)
         ) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_load),
            .clr   (flush),
            .d     (in_data),
            .q     (skid_q)
         );

         assign in_ready  = in_ready_q;
         assign out_valid = out_valid_q;
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Stall counter: counts cycles where a valid payload is blocked. Flush
   // deliberately leaves it alone so squashes do not hide stall history.
   // -----------------------------------------------------------------------
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d = '0;
      end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances side by side:
//   u_s : SKID=1, N=32, RESET_VAL=NOP_INST, CNT_W=4
//   u_z : SKID=0, N=32, RESET_VAL=32'hDEAD_BEEF, CNT_W=16
// Inputs change 1 time unit after the rising edge; a scoreboard per
// instance samples on the falling edge, pushes each accepted payload and
// pops/compares each delivered one.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;
   import cpu_pkg::*;

   localparam logic [31:0] Z_RST = 32'hDEAD_BEEF;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   logic        s_flush = 0, s_in_valid = 0, s_out_ready = 0, s_cnt_clr = 0;
   logic [31:0] s_in_data = '0;
   logic        s_in_ready, s_out_valid;
   logic [31:0] s_out_data;
   logic [3:0]  s_stall_cnt;

   logic        z_flush = 0, z_in_valid = 0, z_out_ready = 0, z_cnt_clr = 0;
   logic [31:0] z_in_data = '0;
   logic        z_in_ready, z_out_valid;
   logic [31:0] z_out_data;
   logic [15:0] z_stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } sb_t;

   sb_t q_s[$];
   sb_t q_z[$];
   sb_t e_s, e_z, n_s, n_z;
   int  cyc_s = 0, cyc_z = 0;
   int  push_s = 0, push_z = 0, pop_s = 0, pop_z = 0;
   bit  lat_chk = 1'b0;

   pipe_stage_reg #(.N(32), .SKID(1), .RESET_VAL(NOP_INST), .CNT_W(4)) u_s (
      .clk(clk), .reset(reset), .flush(s_flush),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .stall_cnt(s_stall_cnt), .cnt_clr(s_cnt_clr)
   );

   pipe_stage_reg #(.N(32), .SKID(0), .RESET_VAL(Z_RST), .CNT_W(16)) u_z (
      .clk(clk), .reset(reset), .flush(z_flush),
      .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
      .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
      .stall_cnt(z_stall_cnt), .cnt_clr(z_cnt_clr)
   );

   always #5 clk = ~clk;

   // Scoreboard for u_s: downstream pop first, then flush squash or push.
   always @(negedge clk) begin
      if (reset) begin
         q_s.delete();
      end else begin
         if (s_out_valid && s_out_ready) begin
            n_tests++;
            pop_s++;
            if (q_s.size() == 0) begin
               n_fail++;
               $display("FAIL sb_s_extra: got %h, expected nothing", s_out_data);
            end else begin
               e_s = q_s.pop_front();
               if (s_out_data !== e_s.data) begin
                  n_fail++;
                  $display("FAIL sb_s_data: got %h, expected %h", s_out_data, e_s.data);
               end
               if (lat_chk) begin
                  n_tests++;
                  if (cyc_s != e_s.cyc + 1) begin
                     n_fail++;
                     $display("FAIL sb_s_latency: got %0d cycles, expected 1", cyc_s - e_s.cyc);
                  end
               end
            end
         end
         if (s_flush) begin
            q_s.delete();
         end else if (s_in_valid && s_in_ready) begin
            n_s.data = s_in_data;
            n_s.cyc  = cyc_s;
            q_s.push_back(n_s);
            push_s++;
         end
      end
      cyc_s++;
   end

   // Scoreboard for u_z.
   always @(negedge clk) begin
      if (reset) begin
         q_z.delete();
      end else begin
         if (z_out_valid && z_out_ready) begin
            n_tests++;
            pop_z++;
            if (q_z.size() == 0) begin
               n_fail++;
               $display("FAIL sb_z_extra: got %h, expected nothing", z_out_data);
            end else begin
               e_z = q_z.pop_front();
               if (z_out_data !== e_z.data) begin
                  n_fail++;
                  $display("FAIL sb_z_data: got %h, expected %h", z_out_data, e_z.data);
               end
               if (lat_chk) begin
                  n_tests++;
                  if (cyc_z != e_z.cyc + 1) begin
                     n_fail++;
                     $display("FAIL sb_z_latency: got %0d cycles, expected 1", cyc_z - e_z.cyc);
                  end
               end
            end
         end
         if (z_flush) begin
            q_z.delete();
         end else if (z_in_valid && z_in_ready) begin
            n_z.data = z_in_data;
            n_z.cyc  = cyc_z;
            q_z.push_back(n_z);
            push_z++;
         end
      end
      cyc_z++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      #1 reset = 1'b1;
      #2;
      n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL por_s_valid: got %b, expected 0", s_out_valid); end
      n_tests++; if (s_out_data !== NOP_INST) begin n_fail++; $display("FAIL por_s_data: got %h, expected %h", s_out_data, NOP_INST); end
      n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL por_s_ready: got %b, expected 1", s_in_ready); end
      n_tests++; if (z_out_data !== Z_RST) begin n_fail++; $display("FAIL por_z_data: got %h, expected %h", z_out_data, Z_RST); end
      n_tests++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL por_z_ready: got %b, expected 1", z_in_ready); end
      tick();
      reset = 1'b0;
      // Stream 0xA, 0xB into a stalled u_s, then reset between edges.
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 32'hA;
      tick();
      s_in_data   = 32'hB;
      tick();
      n_tests++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL pre_rst_ready: got %b, expected 0", s_in_ready); end
      n_tests++; if (s_stall_cnt !== 4'd1) begin n_fail++; $display("FAIL pre_rst_cnt: got %0d, expected 1", s_stall_cnt); end
      tick();
      #2 reset = 1'b1;
      #1;
      n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", s_out_valid); end
      n_tests++; if (s_out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h, expected 0", s_out_data); end
      n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, expected 1", s_in_ready); end
      n_tests++; if (s_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d, expected 0", s_stall_cnt); end
      s_in_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b, expected 1", s_in_ready); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_backpressure();
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 32'h11;
      tick();
      n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_one_ready: got %b, expected 1", s_in_ready); end
      n_tests++; if (s_out_data !== 32'h11) begin n_fail++; $display("FAIL bp_one_data: got %h, expected 11", s_out_data); end
      s_in_data = 32'h22;
      tick();
      n_tests++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b, expected 0", s_in_ready); end
      n_tests++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid: got %b, expected 1", s_out_valid); end
      s_in_data = 32'h33;
      tick();
      n_tests++; if (s_out_data !== 32'h11) begin n_fail++; $display("FAIL bp_hold_data: got %h, expected 11", s_out_data); end
      n_tests++; if (s_stall_cnt !== 4'd2) begin n_fail++; $display("FAIL bp_hold_cnt: got %0d, expected 2", s_stall_cnt); end
      s_out_ready = 1'b1;
      #1;
      // Registered ready: raising out_ready must not reopen in_ready yet.
      n_tests++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_reg_ready: got %b, expected 0", s_in_ready); end
      tick();
      n_tests++; if (s_out_data !== 32'h22) begin n_fail++; $display("FAIL bp_drain1: got %h, expected 22", s_out_data); end
      n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain1_ready: got %b, expected 1", s_in_ready); end
      tick();
      n_tests++; if (s_out_data !== 32'h33) begin n_fail++; $display("FAIL bp_drain2: got %h, expected 33", s_out_data); end
      s_in_valid = 1'b0;
      tick();
      n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b, expected 0", s_out_valid); end
      n_tests++; if (s_stall_cnt !== 4'd2) begin n_fail++; $display("FAIL bp_cnt: got %0d, expected 2", s_stall_cnt); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_streaming();
      int ps0, pz0;
      s_cnt_clr = 1'b1;
      z_cnt_clr = 1'b1;
      tick();
      s_cnt_clr = 1'b0;
      z_cnt_clr = 1'b0;
      s_out_ready = 1'b1;
      z_out_ready = 1'b1;
      lat_chk = 1'b1;
      ps0 = pop_s;
      pz0 = pop_z;
      for (int i = 0; i < 100; i++) begin
         s_in_valid = 1'b1;
         s_in_data  = $urandom;
         z_in_valid = 1'b1;
         z_in_data  = $urandom;
         #1;
         n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_s_ready[%0d]: got %b, expected 1", i, s_in_ready); end
         n_tests++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_z_ready[%0d]: got %b, expected 1", i, z_in_ready); end
         tick();
      end
      s_in_valid = 1'b0;
      z_in_valid = 1'b0;
      tick();
      lat_chk = 1'b0;
      n_tests++; if (pop_s - ps0 != 100) begin n_fail++; $display("FAIL stream_s_count: got %0d, expected 100", pop_s - ps0); end
      n_tests++; if (pop_z - pz0 != 100) begin n_fail++; $display("FAIL stream_z_count: got %0d, expected 100", pop_z - pz0); end
      n_tests++; if (s_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stream_s_cnt: got %0d, expected 0", s_stall_cnt); end
      n_tests++; if (z_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_z_cnt: got %0d, expected 0", z_stall_cnt); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_flush();
      // u_s: fill to FULL, then flush while 0x44 is offered.
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 32'h55;
      tick();
      s_in_data   = 32'h66;
      tick();
      s_in_data   = 32'h44;
      s_flush     = 1'b1;
      tick();
      s_flush     = 1'b0;
      s_in_valid  = 1'b0;
      n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_s_valid: got %b, expected 0", s_out_valid); end
      n_tests++; if (s_out_data !== NOP_INST) begin n_fail++; $display("FAIL fl_s_data: got %h, expected %h", s_out_data, NOP_INST); end
      n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_s_ready: got %b, expected 1", s_in_ready); end
      s_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_s_ghost[%0d]: got valid data %h, expected none", i, s_out_data); end
      end
      s_in_valid = 1'b1;
      s_in_data  = 32'h99;
      tick();
      s_in_valid = 1'b0;
      n_tests++; if (s_out_data !== 32'h99) begin n_fail++; $display("FAIL fl_s_resume: got %h, expected 99", s_out_data); end
      tick();

      // u_z: downstream transfer in the flush cycle still completes.
      z_out_ready = 1'b1;
      z_in_valid  = 1'b1;
      z_in_data   = 32'h77;
      tick();
      z_in_data   = 32'h88;
      z_flush     = 1'b1;
      tick();
      z_flush     = 1'b0;
      z_in_valid  = 1'b0;
      n_tests++; if (z_out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_z_valid: got %b, expected 0", z_out_valid); end
      n_tests++; if (z_out_data !== Z_RST) begin n_fail++; $display("FAIL fl_z_data: got %h, expected %h", z_out_data, Z_RST); end
      n_tests++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_z_ready: got %b, expected 1", z_in_ready); end
      tick();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_saturation();
      int exp_cnt;
      s_cnt_clr = 1'b1;
      tick();
      s_cnt_clr   = 1'b0;
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 32'hAB;
      tick();
      s_in_valid  = 1'b0;
      n_tests++; if (s_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_start: got %0d, expected 0", s_stall_cnt); end
      for (int i = 0; i < 20; i++) begin
         tick();
         exp_cnt = (i + 1 > 15) ? 15 : i + 1;
         n_tests++; if (s_stall_cnt !== 4'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d, expected %0d", i, s_stall_cnt, exp_cnt); end
      end
      s_cnt_clr = 1'b1;
      tick();
      s_cnt_clr = 1'b0;
      n_tests++; if (s_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr: got %0d, expected 0", s_stall_cnt); end
      tick();
      n_tests++; if (s_stall_cnt !== 4'd1) begin n_fail++; $display("FAIL sat_after_clr: got %0d, expected 1", s_stall_cnt); end
      // Flush squashes the payload but leaves the counter counting.
      s_flush = 1'b1;
      tick();
      s_flush = 1'b0;
      n_tests++; if (s_stall_cnt !== 4'd2) begin n_fail++; $display("FAIL sat_flush_cnt: got %0d, expected 2", s_stall_cnt); end
      n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_flush_valid: got %b, expected 0", s_out_valid); end
      tick();
      n_tests++; if (s_stall_cnt !== 4'd2) begin n_fail++; $display("FAIL sat_idle_cnt: got %0d, expected 2", s_stall_cnt); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_comb_ready_random();
      z_out_ready = 1'b0;
      z_in_valid  = 1'b1;
      z_in_data   = 32'h1234;
      tick();
      z_in_valid  = 1'b0;
      z_out_ready = 1'b0;
      #1;
      n_tests++; if (z_in_ready !== 1'b0) begin n_fail++; $display("FAIL comb_rdy_lo1: got %b, expected 0", z_in_ready); end
      z_out_ready = 1'b1;
      #1;
      n_tests++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL comb_rdy_hi: got %b, expected 1", z_in_ready); end
      z_out_ready = 1'b0;
      #1;
      n_tests++; if (z_in_ready !== 1'b0) begin n_fail++; $display("FAIL comb_rdy_lo2: got %b, expected 0", z_in_ready); end
      tick();

      for (int i = 0; i < 1000; i++) begin
         s_in_valid  = 1'($urandom_range(0, 1));
         s_in_data   = $urandom;
         s_out_ready = 1'($urandom_range(0, 1));
         z_in_valid  = 1'($urandom_range(0, 1));
         z_in_data   = $urandom;
         z_out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      s_in_valid  = 1'b0;
      z_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      z_out_ready = 1'b1;
      repeat (4) tick();
      n_tests++; if (q_s.size() != 0) begin n_fail++; $display("FAIL rnd_s_lost: got %0d undelivered, expected 0", q_s.size()); end
      n_tests++; if (q_z.size() != 0) begin n_fail++; $display("FAIL rnd_z_lost: got %0d undelivered, expected 0", q_z.size()); end
      n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_s_idle: got %b, expected 0", s_out_valid); end
      n_tests++; if (z_out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_z_idle: got %b, expected 0", z_out_valid); end
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_streaming();
      test_flush();
      test_saturation();
      test_comb_ready_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_reg
